key_entry_collector: RTL
========================

Name: key_entry_collector

Overview:
- Upstream stage of the seven-segment display decoder, alongside the lock state machine.
- Captures presses on the four active-low push-buttons and converts each one to a one-hot 4-bit key code.
- Packs the last KEY_NUMBERS codes into the key-value store bus read by the display decoder and the password compare logic.
- Raises completion and inactivity-timeout pulses that drive the lock FSM's *_KEY_INPUT_DISPLAY, *_OVERTIME and compare transitions.

Parameters:
- KEY_NUMBERS, 4: presses per entry (password length), range 1..DIGIT_SLOTS.
- KEY_WIDTH, 4: physical keys; also width of one stored code.
- DIGIT_SLOTS, 6: display digits covered by keyValueStore.
- TIMEOUT_CYCLES, 250000000: inactivity limit in clock cycles (5 s at 50 MHz).
- COUNT_WIDTH, 28: timeout counter width; must hold TIMEOUT_CYCLES-1.
- DEBOUNCE_CYCLES, 1000000: stability window in cycles; used only with DEBOUNCE_EN.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- key_n  in  KEY_WIDTH  raw push-buttons, low = pressed, asynchronous to clock.
- enable  in  1  lock FSM is in a key-entry state; presses are ignored when low.
- clear  in  1  synchronous wipe of the store, count and FSM.
- keyValueStore  out  KEY_WIDTH*DIGIT_SLOTS  packed codes; slot 0 (bits 3:0) is the newest press.
- keyCount  out  3  presses held, 0..KEY_NUMBERS.
- entryActive  out  1  high while in COLLECT.
- entryDone  out  1  one-cycle pulse when the KEY_NUMBERS-th press is stored.
- entryTimeout  out  1  one-cycle pulse on inactivity timeout.

Behaviour:
- Reset: keyValueStore=0, keyCount=0, entryActive=0, entryDone=0, entryTimeout=0, timeout counter=0, FSM=IDLE. Synchroniser flops reset to all-ones (released).
- Input path: key_n passes through two flops, is inverted to active-high keys, then goes to an edge register.
- Valid press: exactly one key bit rises while all other keys were released on the previous sample. Simultaneous or overlapping presses are ignored. Releases generate nothing.
- Press-to-store latency without debounce: 3 clock edges from the key_n fall to the keyValueStore update.
- Store update: keyValueStore shifts up one slot and the new one-hot code is written into slot 0. Slots at index KEY_NUMBERS and above are forced to 0.
- IDLE:
  - Valid press with enable=1: store ← {0…, code}, keyCount=1, counter=0, go to COLLECT.
  - If KEY_NUMBERS=1, go straight to the done path instead.
- COLLECT:
  - Counter increments every cycle and resets to 0 on each valid press.
  - Valid press: shift in, keyCount+1.
  - When keyCount reaches KEY_NUMBERS: pulse entryDone the same cycle the last code is stored, go to IDLE, store held.
  - Counter == TIMEOUT_CYCLES-1 with no press that cycle: pulse entryTimeout, clear store and keyCount, go to IDLE.
- Held result: after entryDone the store stays unchanged until clear or the next valid first press. That press clears the store before writing slot 0.
- Precedence, highest first: reset_n, clear, enable=0, valid press, timeout.
  - enable=0 in COLLECT: abort to IDLE, clear store and count, no pulse.
  - Press and timeout in the same cycle: the press wins, counter resets.
- entryActive = (FSM==COLLECT), registered.
- Reset asserted mid-entry: all outputs return to their reset values immediately (asynchronous).

Optional Feature:
- Macro: DEBOUNCE_EN.
- Defined:
  - Each synchronised key has its own counter; the key's filtered level changes only after the raw level has been stable for DEBOUNCE_CYCLES consecutive cycles.
  - Edge detection runs on the filtered levels.
  - Latency = 3 + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than the window produces no press.
- Undefined: no filter and no debounce counters; edge detection runs on the synchroniser output; DEBOUNCE_CYCLES is unused.

Test Plan (TIMEOUT_CYCLES=20, DEBOUNCE_CYCLES=4, KEY_NUMBERS=4, unless stated):
- Press keys 0,1,2,3 in order, enable=1 -> keyValueStore=24'h001248, keyCount=4, entryDone high for exactly 1 cycle, entryActive falls.
- Press keys 0,1, then idle 20 cycles -> entryTimeout pulses exactly 19 cycles after the second store, then keyValueStore=0 and keyCount=0.
- Press key_n=4'b1100 (two keys) -> no store change; then release and press key 2 alone -> slot0=4'b0100.
- After a completed entry, press key 3 -> keyValueStore=24'h000008, keyCount=1.
- clear asserted in the same cycle as a valid press, and separately reset_n pulsed mid-entry -> store=0, count=0, no pulses.
- With DEBOUNCE_EN: key_n low for 3 cycles -> nothing stored; low for 6 cycles -> one press, slot0 updated at 3+4 cycles.

Source files
------------

// File: rtl/key_entry_collector.sv
// Push-button entry collector: synchronises key_n, detects single-key presses and packs their one-hot codes for the lock FSM.
// Define DEBOUNCE_EN to add a per-key stability filter of DEBOUNCE_CYCLES ahead of edge detection.
module key_entry_collector #(
    parameter int KEY_NUMBERS     = 4,
    parameter int KEY_WIDTH       = 4,
    parameter int DIGIT_SLOTS     = 6,
    parameter int TIMEOUT_CYCLES  = 250000000,
    parameter int COUNT_WIDTH     = 28,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [KEY_WIDTH-1:0]             key_n,
    input  logic                             enable,
    input  logic                             clear,
    output logic [KEY_WIDTH*DIGIT_SLOTS-1:0] keyValueStore,
    output logic [2:0]                       keyCount,
    output logic                             entryActive,
    output logic                             entryDone,
    output logic                             entryTimeout
);

    localparam int STORE_WIDTH = KEY_WIDTH * DIGIT_SLOTS;
    localparam logic [STORE_WIDTH-1:0] SLOT_MASK =
        (STORE_WIDTH'(1) << (KEY_NUMBERS * KEY_WIDTH)) - STORE_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_HIT = COUNT_WIDTH'(TIMEOUT_CYCLES - 2);
    localparam logic [2:0] LAST_COUNT = 3'(KEY_NUMBERS - 1);

    if (KEY_NUMBERS < 1 || KEY_NUMBERS > DIGIT_SLOTS) begin : gBadKeyNumbers
        $error("key_entry_collector: KEY_NUMBERS must lie in 1..DIGIT_SLOTS");
    end
    if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : gBadTiming
        $error("key_entry_collector: DEBOUNCE_CYCLES must be >= 1 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [0:0] {IDLE, COLLECT} entryState_t;

    entryState_t            state;
    logic [KEY_WIDTH-1:0]   keySync1, keySync2;
    logic [KEY_WIDTH-1:0]   keyLevel, keyLevelPrev;
    logic [COUNT_WIDTH-1:0] idleTimer;
    logic                   validPress;
    logic [STORE_WIDTH-1:0] storeShifted, storeFirst;

    // NOTE: synchroniser flops reset to all-ones (released) so leaving reset never looks like a press.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            keySync1 <= '1;
            keySync2 <= '1;
        end else begin
            keySync1 <= key_n;
            keySync2 <= keySync1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int DB_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);

    logic [KEY_WIDTH-1:0][DB_WIDTH-1:0] stableCount;
    logic [KEY_WIDTH-1:0]               keyFiltered;

    // The filtered level follows the raw level only after DEBOUNCE_CYCLES identical samples.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stableCount <= '0;
            keyFiltered <= '0;
        end else begin
            for (int i = 0; i < KEY_WIDTH; i++) begin
                if (~keySync2[i] == keyFiltered[i]) begin
                    stableCount[i] <= '0;
                end else if (stableCount[i] == DB_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
                    keyFiltered[i] <= ~keySync2[i];
                    stableCount[i] <= '0;
                end else begin
                    stableCount[i] <= stableCount[i] + DB_WIDTH'(1);
                end
            end
        end
    end

    assign keyLevel = keyFiltered;
`else
    assign keyLevel = ~keySync2;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            keyLevelPrev <= '0;
        end else begin
            keyLevelPrev <= keyLevel;
        end
    end

    // A press counts only when exactly one key rises out of an all-released sample.
    assign validPress   = (keyLevelPrev == '0) && $onehot(keyLevel);
    assign storeShifted = {keyValueStore[STORE_WIDTH-KEY_WIDTH-1:0], keyLevel} & SLOT_MASK;
    assign storeFirst   = STORE_WIDTH'(keyLevel);

    // NOTE: all state uses non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            keyValueStore <= '0;
            keyCount      <= '0;
            idleTimer     <= '0;
            entryActive   <= 1'b0;
            entryDone     <= 1'b0;
            entryTimeout  <= 1'b0;
        end else begin
            entryDone    <= 1'b0;
            entryTimeout <= 1'b0;
            if (clear) begin
                state         <= IDLE;
                keyValueStore <= '0;
                keyCount      <= '0;
                idleTimer     <= '0;
                entryActive   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (enable && validPress) begin
                            keyValueStore <= storeFirst;
                            keyCount      <= 3'd1;
                            idleTimer     <= '0;
                            if (KEY_NUMBERS == 1) begin
                                entryDone <= 1'b1;
                            end else begin
                                state       <= COLLECT;
                                entryActive <= 1'b1;
                            end
                        end
                    end
                    COLLECT: begin
                        if (!enable) begin
                            state         <= IDLE;
                            keyValueStore <= '0;
                            keyCount      <= '0;
                            idleTimer     <= '0;
                            entryActive   <= 1'b0;
                        end else if (validPress) begin
                            keyValueStore <= storeShifted;
                            keyCount      <= keyCount + 3'd1;
                            idleTimer     <= '0;
                            if (keyCount == LAST_COUNT) begin
                                state       <= IDLE;
                                entryActive <= 1'b0;
                                entryDone   <= 1'b1;
                            end
                        end else if (idleTimer == TIMEOUT_HIT) begin
                            // Fires on the edge where the timer would reach TIMEOUT_CYCLES-1.
                            state         <= IDLE;
                            keyValueStore <= '0;
                            keyCount      <= '0;
                            idleTimer     <= '0;
                            entryActive   <= 1'b0;
                            entryTimeout  <= 1'b1;
                        end else begin
                            idleTimer <= idleTimer + COUNT_WIDTH'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule
